// File: rtl/student_sample_sequencer_pkg.sv
// Shared types for the FIR sample delay-line controller.
// Holds the sample type, sequencer state names and tap-index width helper.
package student_fir_pkg;

    localparam int SampleW = 16;

    typedef logic [SampleW-1:0] sample_t;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

    // Tap index needs at least one bit even for a single-tap filter.
    function automatic int tap_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/student_sample_sequencer_if.sv
// Valid/ready sample handshake into the delay-line controller.
// master: producer drives valid/data; slave: controller drives ready.
interface student_sample_sequencer_if #(
    parameter int DataSize = 16
) ();

    logic                valid;
    logic                ready;
    logic [DataSize-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/student_sample_sequencer.sv
// FIR delay-line controller: writes each accepted sample to a circular
// pointer in an external dual-port RAM, then streams the NumTaps newest
// samples (newest first) with tap index and last flag; zero-fills the
// RAM after reset or on request.
// Ports: clk_i, rst_i (sync, active-high), clear_i, sample (slave
// handshake), RAM port A (ena/wea/addra/dia), RAM port B (enb/addrb/dob),
// tap stream (valid/data/idx/last), busy_o.
module student_sample_sequencer
    import student_fir_pkg::*;
#(
    parameter int AddrWidth = 10,
    parameter int DataSize  = 16,
    parameter int NumTaps   = 64,
    localparam int TapIdxW  = tap_idx_width(NumTaps)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    student_sample_sequencer_if.slave sample,
    output logic                 ram_ena_o,
    output logic                 ram_wea_o,
    output logic [AddrWidth-1:0] ram_addra_o,
    output logic [DataSize-1:0]  ram_dia_o,
    output logic                 ram_enb_o,
    output logic [AddrWidth-1:0] ram_addrb_o,
    input  logic [DataSize-1:0]  ram_dob_i,
    output logic                 tap_valid_o,
    output logic [DataSize-1:0]  tap_data_o,
    output logic [TapIdxW-1:0]   tap_idx_o,
    output logic                 tap_last_o,
    output logic                 busy_o
);

    localparam int Depth = 1 << AddrWidth;

    localparam logic [1:0] ST_CLEAR = CLEAR;
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_READ  = READ;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    localparam logic [TapIdxW-1:0] KLast = TapIdxW'(NumTaps - 1);

    if (AddrWidth < 1 || AddrWidth > 30) begin : g_bad_aw
        $error("AddrWidth out of range");
    end

    if (NumTaps < 1 || NumTaps > Depth) begin : g_bad_taps
        $error("NumTaps must be within 1..2**AddrWidth");
    end

    logic [1:0]           state;
    logic [AddrWidth-1:0] wptr;
    logic [AddrWidth-1:0] clr_cnt;
    logic [TapIdxW-1:0]   rd_cnt;

    logic                 tap_valid_q;
    logic [TapIdxW-1:0]   tap_idx_q;
    logic                 tap_last_q;

    logic                 ready;
    logic                 rd_issue;
    logic                 rd_final;

    assign rd_issue = (state == ST_READ);
    assign rd_final = rd_issue && (rd_cnt == KLast);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_CLEAR;
            wptr        <= '0;
            clr_cnt     <= '0;
            rd_cnt      <= '0;
            tap_valid_q <= 1'b0;
            tap_idx_q   <= '0;
            tap_last_q  <= 1'b0;
        end else begin
            // Issue-cycle tap tags, aligned with the RAM's read latency.
            tap_valid_q <= rd_issue;
            tap_idx_q   <= rd_issue ? rd_cnt : '0;
            tap_last_q  <= rd_final;

            unique case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + AddrWidth'(1);
                    if (clr_cnt == '1) begin
                        state <= ST_IDLE;
                        wptr  <= '0;
                    end
                end
                ST_IDLE: begin
                    if (sample.valid) begin
                        state  <= ST_READ;
                        rd_cnt <= '0;
                    end else if (clear_i) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_READ: begin
                    if (rd_final) begin
                        state <= ST_DRAIN;
                    end else begin
                        rd_cnt <= rd_cnt + TapIdxW'(1);
                    end
                end
                ST_DRAIN: begin
                    wptr  <= wptr + AddrWidth'(1);
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    // All strobes are forced low while reset is held, so the external
    // RAM sees no stray write in the cycle reset is first asserted.
    always_comb begin
        ready       = 1'b0;
        ram_ena_o   = 1'b0;
        ram_wea_o   = 1'b0;
        ram_addra_o = '0;
        ram_dia_o   = '0;
        ram_enb_o   = 1'b0;
        ram_addrb_o = '0;
        if (!rst_i) begin
            unique case (state)
                ST_CLEAR: begin
                    ram_ena_o   = 1'b1;
                    ram_wea_o   = 1'b1;
                    ram_addra_o = clr_cnt;
                end
                ST_IDLE: begin
                    ready = 1'b1;
                    if (sample.valid) begin
                        ram_ena_o   = 1'b1;
                        ram_wea_o   = 1'b1;
                        ram_addra_o = wptr;
                        ram_dia_o   = sample.data;
                    end
                end
                ST_READ: begin
                    // Newest first; wraps to the top of the RAM.
                    ram_enb_o   = 1'b1;
                    ram_addrb_o = wptr - AddrWidth'(rd_cnt);
                end
                default: begin
                    ram_enb_o = 1'b0;
                end
            endcase
        end
    end

    assign sample.ready = ready;

    assign tap_valid_o = tap_valid_q && !rst_i;
    assign tap_idx_o   = rst_i ? '0 : tap_idx_q;
    assign tap_last_o  = tap_last_q && !rst_i;
    assign tap_data_o  = rst_i ? '0 : ram_dob_i;
    assign busy_o      = !rst_i && (state != ST_IDLE);

endmodule

// File: tb/tb_student_sample_sequencer.sv
// Testbench for student_sample_sequencer with a behavioural RAM model,
// directed scenarios with literal expectations and a randomized phase.
module tb_student_sample_sequencer;
    import student_fir_pkg::*;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NT = 4;
    localparam int D  = 16;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    logic clear;

    always #5 clk = ~clk;

    student_sample_sequencer_if #(.DataSize(DW)) sif ();

    logic          ena, wea, enb;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dia, dob;
    logic          tap_valid, tap_last, busy;
    logic [DW-1:0] tap_data;
    logic [IW-1:0] tap_idx;

    student_sample_sequencer #(
        .AddrWidth(AW),
        .DataSize (DW),
        .NumTaps  (NT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (clear),
        .sample     (sif),
        .ram_ena_o  (ena),
        .ram_wea_o  (wea),
        .ram_addra_o(addra),
        .ram_dia_o  (dia),
        .ram_enb_o  (enb),
        .ram_addrb_o(addrb),
        .ram_dob_i  (dob),
        .tap_valid_o(tap_valid),
        .tap_data_o (tap_data),
        .tap_idx_o  (tap_idx),
        .tap_last_o (tap_last),
        .busy_o     (busy)
    );

    logic [DW-1:0] mem [D];

    always @(posedge clk) begin
        if (ena && wea) mem[addra] <= dia;
        if (enb) dob <= mem[addrb];
    end

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        else
            n_pass++;
    endtask

    logic [DW-1:0] taps[$];
    logic [AW-1:0] addrbs[$];
    int            acc_cyc[$];

    always @(negedge clk) begin
        if (!rst && tap_valid) taps.push_back(tap_data);
        if (!rst && enb) addrbs.push_back(addrb);
        if (!rst && sif.ready && sif.valid) acc_cyc.push_back(cyc);
    end

    // Reference: clear phase of D cycles, then idle; each accept opens a
    // burst of NT read cycles plus one drain cycle. Tap k of a burst is
    // the k-th most recent sample since the last clear, or 0 if none.
    initial begin : model
        int      clr_left;
        int      burst_t;
        int      nacc;
        int      k;
        int      j;
        bit      inited;
        sample_t hist[$];
        clr_left = 0;
        burst_t  = 0;
        nacc     = 0;
        inited   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ready", sif.ready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_ena", ena, 0);
                chk("rst_wea", wea, 0);
                chk("rst_enb", enb, 0);
                chk("rst_tap_valid", tap_valid, 0);
                chk("rst_tap_data", tap_data, 0);
            end else if (inited) begin
                if (clr_left > 0) begin
                    chk("clr_busy", busy, 1);
                    chk("clr_ready", sif.ready, 0);
                    chk("clr_ena", ena, 1);
                    chk("clr_wea", wea, 1);
                    chk("clr_addra", addra, D - clr_left);
                    chk("clr_dia", dia, 0);
                    chk("clr_enb", enb, 0);
                    chk("clr_tap_valid", tap_valid, 0);
                end else if (burst_t == 0) begin
                    chk("idle_ready", sif.ready, 1);
                    chk("idle_busy", busy, 0);
                    chk("idle_ena", ena, sif.valid);
                    chk("idle_wea", wea, sif.valid);
                    chk("idle_enb", enb, 0);
                    chk("idle_tap_valid", tap_valid, 0);
                    if (sif.valid) begin
                        chk("wr_addra", addra, nacc % D);
                        chk("wr_dia", dia, sif.data);
                    end
                end else begin
                    chk("burst_ready", sif.ready, 0);
                    chk("burst_busy", busy, 1);
                    chk("burst_wea", wea, 0);
                    chk("burst_enb", enb, burst_t <= NT);
                    if (burst_t <= NT)
                        chk("rd_addrb", addrb, ((nacc - burst_t) % D + D) % D);
                    chk("tap_valid", tap_valid, burst_t >= 2);
                    if (burst_t >= 2) begin
                        k = burst_t - 2;
                        j = nacc - 1 - k;
                        chk("tap_idx", tap_idx, k);
                        chk("tap_last", tap_last, k == NT - 1);
                        chk("tap_data", tap_data, (j >= 0) ? hist[j] : 0);
                    end
                end
            end
            @(posedge clk);
            if (rst) begin
                clr_left = D;
                burst_t  = 0;
                nacc     = 0;
                hist.delete();
                inited   = 1;
            end else if (inited) begin
                if (clr_left > 0) begin
                    clr_left--;
                end else if (burst_t > 0) begin
                    burst_t++;
                    if (burst_t > NT + 1) burst_t = 0;
                end else if (sif.valid) begin
                    hist.push_back(sif.data);
                    nacc++;
                    burst_t = 1;
                end else if (clear) begin
                    clr_left = D;
                    nacc     = 0;
                    hist.delete();
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!sif.ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", sif.ready, 1);
    endtask

    task automatic idle_sync();
        wait_ready();
        @(posedge clk);
        #1;
    endtask

    // Keeps valid high across samples; data changes only after a handshake.
    task automatic stream(input int first, input int cnt);
        bit hs;
        int n;
        for (int i = 0; i < cnt; i++) begin
            sif.valid = 1'b1;
            sif.data  = DW'(first + i);
            hs = 0;
            n  = 0;
            while (!hs && n < 100) begin
                @(negedge clk);
                hs = sif.ready;
                @(posedge clk);
                #1;
                n++;
            end
            chk("accept", hs, 1);
        end
        sif.valid = 1'b0;
    endtask

    task automatic chk_last4(input string name, input int e0, input int e1,
                             input int e2, input int e3);
        int e[4];
        int s;
        e = '{e0, e1, e2, e3};
        s = taps.size();
        chk({name, "_count"}, s >= 4, 1);
        for (int i = 0; i < 4; i++)
            if (s >= 4)
                chk($sformatf("%s_k%0d", name, i), taps[s - 4 + i], e[i]);
    endtask

    initial begin : stim
        int n;
        int s;
        bit hs;
        rst       = 1'b1;
        clear     = 1'b0;
        sif.valid = 1'b0;
        sif.data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lit_rst_ready", sif.ready, 0);
        chk("lit_rst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        n = 0;
        @(negedge clk);
        while (!sif.ready && n < 100) begin
            if (busy && ena && wea && dia == 0 && addra == AW'(n)) n++;
            @(negedge clk);
        end
        chk("lit_clear_len", n, 16);
        @(posedge clk);
        #1;

        taps.delete();
        acc_cyc.delete();
        stream(1, 3);
        idle_sync();
        chk_last4("lit_burst3", 3, 2, 1, 0);
        chk("lit_acc_count", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            chk("lit_gap1", acc_cyc[1] - acc_cyc[0], 6);
            chk("lit_gap2", acc_cyc[2] - acc_cyc[1], 6);
        end

        addrbs.delete();
        stream(4, 17);
        idle_sync();
        chk_last4("lit_burst20", 20, 19, 18, 17);
        s = addrbs.size();
        chk("lit_addrb_count", s >= 4, 1);
        if (s >= 4) begin
            chk("lit_addrb0", addrbs[s - 4], 3);
            chk("lit_addrb1", addrbs[s - 3], 2);
            chk("lit_addrb2", addrbs[s - 2], 1);
            chk("lit_addrb3", addrbs[s - 1], 0);
        end

        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("lit_clear_busy", busy, 1);
        idle_sync();
        stream(9, 1);
        idle_sync();
        chk_last4("lit_after_clear", 9, 0, 0, 0);

        clear = 1'b1;
        stream('h55, 1);
        clear = 1'b0;
        idle_sync();
        chk_last4("lit_valid_wins", 'h55, 9, 0, 0);

        stream('h77, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("lit_abort_tv", tap_valid, 0);
        chk("lit_abort_addra", addra, 0);
        chk("lit_abort_ena", ena, 1);
        chk("lit_abort_ready", sif.ready, 0);
        n = 1;
        @(negedge clk);
        while (!sif.ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("lit_abort_clear_len", n, 16);
        @(posedge clk);
        #1;

        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            hs = sif.ready && sif.valid;
            @(posedge clk);
            #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            clear = ($urandom_range(0, 19) == 0);
            if (!sif.valid || hs) begin
                sif.valid = ($urandom_range(0, 2) == 0);
                sif.data  = DW'($urandom);
            end
        end

        rst       = 1'b0;
        clear     = 1'b0;
        sif.valid = 1'b0;
        repeat (30) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
